// File: rtl/sync_ptr_gray_if.sv
// sync_ptr_gray_if: bundle between a FIFO pointer source and its synchroniser.
// master drives wptr/sync_clr; slave returns gray, binary, strobe, delta, error.
interface sync_ptr_gray_if #(
  parameter int FIFO_ADDRSIZE = 2
);
  localparam int W = FIFO_ADDRSIZE + 1;

  logic [W-1:0] wptr;
  logic         sync_clr;
  logic [W-1:0] rq_wptr;
  logic [W-1:0] rq_wptr_bin;
  logic         ptr_upd;
  logic [W-1:0] ptr_delta;
  logic         ptr_err;

  modport master (
    output wptr,
    output sync_clr,
    input  rq_wptr,
    input  rq_wptr_bin,
    input  ptr_upd,
    input  ptr_delta,
    input  ptr_err
  );

  modport slave (
    input  wptr,
    input  sync_clr,
    output rq_wptr,
    output rq_wptr_bin,
    output ptr_upd,
    output ptr_delta,
    output ptr_err
  );
endinterface

// File: rtl/sync_ptr_gray.sv
// sync_ptr_gray: gray pointer synchroniser with binary, strobe, delta, overrun.
// Ports: rclk, rrst_n (async low), bus (slave: wptr/sync_clr in, results out).
module sync_ptr_gray #(
  parameter int FIFO_ADDRSIZE = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int MAX_STEP      = 2 ** FIFO_ADDRSIZE,
  parameter bit CHECK_EN      = 1'b1
) (
  input logic            rclk,
  input logic            rrst_n,
  sync_ptr_gray_if.slave bus
);
  localparam int W = FIFO_ADDRSIZE + 1;

  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("sync_ptr_gray: SYNC_STAGES must be >= 2");
  end

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  (* ASYNC_REG = "TRUE" *)
  logic [W-1:0] r_sync [SYNC_STAGES];

  logic [W-1:0] r_prev;
  logic [W-1:0] r_bin;
  logic [W-1:0] r_delta;
  logic         r_upd;
  logic         r_err;

  logic [W-1:0] w_gray;
  logic [W-1:0] w_bin;
  logic [W-1:0] w_prev_bin;
  logic [W-1:0] w_delta;
  logic         w_upd;

  // wptr lands directly in stage 0; clear skips sampling on that edge.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else if (bus.sync_clr) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= bus.wptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_gray     = r_sync[SYNC_STAGES-1];
  assign w_bin      = g2b(w_gray);
  assign w_prev_bin = g2b(r_prev);
  assign w_upd      = (w_gray != r_prev);
  // Modulo subtraction absorbs pointer wrap.
  assign w_delta    = w_bin - w_prev_bin;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_prev  <= '0;
      r_bin   <= '0;
      r_upd   <= 1'b0;
      r_delta <= '0;
    end else if (bus.sync_clr) begin
      r_prev  <= '0;
      r_bin   <= '0;
      r_upd   <= 1'b0;
      r_delta <= '0;
    end else begin
      r_prev  <= w_gray;
      r_bin   <= w_bin;
      r_upd   <= w_upd;
      r_delta <= w_delta;
    end
  end

  if (CHECK_EN) begin : g_chk
    logic [31:0] w_delta32;
    logic        w_over;

    assign w_delta32 = 32'(w_delta);
    assign w_over    = w_upd && (w_delta32 > 32'(MAX_STEP));

    always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
        r_err <= 1'b0;
      end else if (bus.sync_clr) begin
        r_err <= 1'b0;
      end else begin
        r_err <= r_err | w_over;
      end
    end
  end else begin : g_nochk
    assign r_err = 1'b0;
  end

  assign bus.rq_wptr     = w_gray;
  assign bus.rq_wptr_bin = r_bin;
  assign bus.ptr_upd     = r_upd;
  assign bus.ptr_delta   = r_delta;
  assign bus.ptr_err     = r_err;
endmodule

// File: tb/tb_sync_ptr_gray.sv
// tb_sync_ptr_gray: scoreboard bench for two synchroniser configurations.
// A: 2-stage, 3-bit, checked; B: 3-stage, 5-bit, check disabled.
module tb_sync_ptr_gray;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  sync_ptr_gray_if #(.FIFO_ADDRSIZE(2)) bus_a ();
  sync_ptr_gray_if #(.FIFO_ADDRSIZE(4)) bus_b ();

  sync_ptr_gray #(
    .FIFO_ADDRSIZE(2),
    .SYNC_STAGES  (2),
    .MAX_STEP     (4),
    .CHECK_EN     (1'b1)
  ) u_a (
    .rclk  (clk),
    .rrst_n(rst_n),
    .bus   (bus_a)
  );

  sync_ptr_gray #(
    .FIFO_ADDRSIZE(4),
    .SYNC_STAGES  (3),
    .MAX_STEP     (16),
    .CHECK_EN     (1'b0)
  ) u_b (
    .rclk  (clk),
    .rrst_n(rst_n),
    .bus   (bus_b)
  );

  typedef struct packed {
    logic [4:0] bin;
    logic       upd;
    logic [4:0] delta;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [4:0] b2g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic exp_t obs_a();
    return {2'b00, bus_a.rq_wptr_bin, bus_a.ptr_upd,
            2'b00, bus_a.ptr_delta, bus_a.ptr_err};
  endfunction

  function automatic exp_t obs_b();
    return {bus_b.rq_wptr_bin, bus_b.ptr_upd,
            bus_b.ptr_delta, bus_b.ptr_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_upd(input bit sel_b, input int limit,
                          output int n);
    n = 0;
    forever begin
      tick();
      n++;
      if (sel_b ? bus_b.ptr_upd : bus_a.ptr_upd) break;
      if (n >= limit) break;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    int   n;
    rst_n = 1'b0;
    bus_a.wptr = 3'b110;
    bus_a.sync_clr = 1'b0;
    bus_b.wptr = '0;
    bus_b.sync_clr = 1'b0;
    repeat (3) tick();
    checks++;
    if (obs_a() !== '0 || bus_a.rq_wptr !== 3'b000) begin
      errors++;
      $display("FAIL reset_a got %h/%h want 0", obs_a(), bus_a.rq_wptr);
    end
    checks++;
    if (obs_b() !== '0 || bus_b.rq_wptr !== 5'b0) begin
      errors++;
      $display("FAIL reset_b got %h/%h want 0", obs_b(), bus_b.rq_wptr);
    end
    rst_n = 1'b1;
    sb_q.push_back('{bin: 5'd4, upd: 1'b1, delta: 5'd4, err: 1'b0});
    tick();
    tick();
    checks++;
    if (bus_a.rq_wptr !== 3'b110) begin
      errors++;
      $display("FAIL reset_exit_gray got %b want 110", bus_a.rq_wptr);
    end
    wait_upd(1'b0, 4, n);
    e = sb_q.pop_front();
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL reset_exit_out got %h want %h", obs_a(), e);
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL reset_exit_lat got %0d want 1", n);
    end
    tick();
    checks++;
    if (bus_a.ptr_upd !== 1'b0 || bus_a.ptr_delta !== 3'd0 ||
        bus_a.rq_wptr_bin !== 3'd4) begin
      errors++;
      $display("FAIL reset_exit_hold got %h want 10_0_0_0", obs_a());
    end
  endtask

  task automatic test_walk();
    exp_t e;
    int   n;
    logic [4:0] seq [8] = '{5'd5, 5'd6, 5'd7, 5'd0,
                            5'd1, 5'd2, 5'd3, 5'd4};
    for (int k = 0; k < 8; k++) begin
      bus_a.wptr = 3'(b2g(seq[k]));
      sb_q.push_back('{bin: seq[k], upd: 1'b1, delta: 5'd1, err: 1'b0});
      wait_upd(1'b0, 8, n);
      e = sb_q.pop_front();
      checks++;
      if (obs_a() !== e) begin
        errors++;
        $display("FAIL walk_%0d got %h want %h", k, obs_a(), e);
      end
      checks++;
      if (n != 3) begin
        errors++;
        $display("FAIL walk_lat_%0d got %0d want 3", k, n);
      end
      tick();
      checks++;
      if (bus_a.ptr_upd !== 1'b0 || bus_a.ptr_delta !== 3'd0) begin
        errors++;
        $display("FAIL walk_pulse_%0d got %h want upd0", k, obs_a());
      end
    end
  endtask

  task automatic test_multi();
    exp_t e;
    int   n;
    bus_a.wptr = 3'b000;
    sb_q.push_back('{bin: 5'd0, upd: 1'b1, delta: 5'd4, err: 1'b0});
    wait_upd(1'b0, 8, n);
    e = sb_q.pop_front();
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL step_eq_max got %h want %h", obs_a(), e);
    end
    tick();
    bus_a.wptr = 3'b010;
    sb_q.push_back('{bin: 5'd3, upd: 1'b1, delta: 5'd3, err: 1'b0});
    wait_upd(1'b0, 8, n);
    e = sb_q.pop_front();
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL multi_step got %h want %h", obs_a(), e);
    end
    tick();
  endtask

  task automatic test_overrun();
    exp_t e;
    int   n;
    int   pulses;
    bus_a.wptr = 3'b000;
    bus_a.sync_clr = 1'b1;
    tick();
    bus_a.sync_clr = 1'b0;
    checks++;
    if (obs_a() !== '0 || bus_a.rq_wptr !== 3'b000) begin
      errors++;
      $display("FAIL clr_pre got %h/%b want 0", obs_a(), bus_a.rq_wptr);
    end
    pulses = 0;
    repeat (4) begin
      tick();
      if (bus_a.ptr_upd) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL clr_quiet got %0d pulses want 0", pulses);
    end
    bus_a.wptr = 3'b111;
    sb_q.push_back('{bin: 5'd5, upd: 1'b1, delta: 5'd5, err: 1'b1});
    wait_upd(1'b0, 8, n);
    e = sb_q.pop_front();
    checks++;
    if (obs_a() !== e) begin
      errors++;
      $display("FAIL overrun got %h want %h", obs_a(), e);
    end
    repeat (3) tick();
    checks++;
    if (bus_a.ptr_err !== 1'b1 || bus_a.ptr_upd !== 1'b0) begin
      errors++;
      $display("FAIL err_sticky got err=%b upd=%b want 1/0",
               bus_a.ptr_err, bus_a.ptr_upd);
    end
    bus_a.wptr = 3'b000;
    bus_a.sync_clr = 1'b1;
    tick();
    bus_a.sync_clr = 1'b0;
    checks++;
    if (obs_a() !== '0 || bus_a.rq_wptr !== 3'b000) begin
      errors++;
      $display("FAIL clr_err got %h/%b want 0", obs_a(), bus_a.rq_wptr);
    end
  endtask

  task automatic test_latency();
    exp_t e;
    int   n;
    logic [4:0] tgt;
    tgt = b2g(5'd5);
    bus_b.wptr = tgt;
    sb_q.push_back('{bin: 5'd5, upd: 1'b1, delta: 5'd5, err: 1'b0});
    n = 0;
    do begin
      tick();
      n++;
    end while (bus_b.rq_wptr !== tgt && n < 8);
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL lat_gray got %0d want 3", n);
    end
    tick();
    e = sb_q.pop_front();
    checks++;
    if (obs_b() !== e) begin
      errors++;
      $display("FAIL lat_upd got %h want %h", obs_b(), e);
    end
    tick();
    checks++;
    if (bus_b.ptr_upd !== 1'b0) begin
      errors++;
      $display("FAIL lat_pulse got %b want 0", bus_b.ptr_upd);
    end
    bus_b.wptr = b2g(5'd22);
    sb_q.push_back('{bin: 5'd22, upd: 1'b1, delta: 5'd17, err: 1'b0});
    wait_upd(1'b1, 8, n);
    e = sb_q.pop_front();
    checks++;
    if (obs_b() !== e) begin
      errors++;
      $display("FAIL nochk_over got %h want %h", obs_b(), e);
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL nochk_lat got %0d want 4", n);
    end
    repeat (2) tick();
    checks++;
    if (bus_b.ptr_err !== 1'b0) begin
      errors++;
      $display("FAIL nochk_err got %b want 0", bus_b.ptr_err);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    exp_t got;
    int   na;
    int   pa;
    int   pb;
    bus_a.wptr = 3'b011;
    bus_b.wptr = '0;
    tick();
    tick();
    checks++;
    if (bus_a.rq_wptr !== 3'b011) begin
      errors++;
      $display("FAIL inflight got %b want 011", bus_a.rq_wptr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_a() !== '0 || bus_a.rq_wptr !== 3'b000 ||
        obs_b() !== '0 || bus_b.rq_wptr !== 5'b0) begin
      errors++;
      $display("FAIL midrst got %h/%h want 0", obs_a(), obs_b());
    end
    tick();
    rst_n = 1'b1;
    sb_q.push_back('{bin: 5'd2, upd: 1'b1, delta: 5'd2, err: 1'b0});
    na = 0;
    pa = 0;
    pb = 0;
    got = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus_b.ptr_upd) pb++;
      if (bus_a.ptr_upd) begin
        pa++;
        if (na == 0) begin
          na = i + 1;
          got = obs_a();
        end
      end
    end
    e = sb_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL midrst_exit got %h want %h", got, e);
    end
    checks++;
    if (na != 3 || pa != 1) begin
      errors++;
      $display("FAIL midrst_lat got lat=%0d n=%0d want 3/1", na, pa);
    end
    checks++;
    if (pb != 0) begin
      errors++;
      $display("FAIL midrst_spurious got %0d want 0", pb);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_walk();
    test_multi();
    test_overrun();
    test_latency();
    test_mid_reset();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_left got %0d want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
